// File: rtl/mem_arbiter.sv
// Two-port round-robin arbiter sharing one single-port BSRAM between fetch (port 0) and load/store (port 1).
// Define MEM_ARB_TIMEOUT_EN to build the ACK/WAIT watchdog (limit set by TIMEOUT).
module mem_arbiter #(
  parameter int ADDR_W  = 14,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0_valid,
  input  logic              req0_we,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_wdata,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic              req1_we,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_wdata,
  output logic              req1_ready,
  output logic              resp0_valid,
  output logic [DATA_W-1:0] resp0_rdata,
  output logic              resp0_err,
  output logic              resp1_valid,
  output logic [DATA_W-1:0] resp1_rdata,
  output logic              resp1_err,
  output logic              mem_available,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_write,
  input  logic [DATA_W-1:0] mem_read,
  input  logic              mem_output_available,
  output logic              timeout_err
);

  if (TIMEOUT < 4 || TIMEOUT > 255) begin : g_timeout_range
    $error("mem_arbiter: TIMEOUT must be in 4..255");
  end

  typedef enum logic [2:0] {IDLE, ISSUE, ACK, WAIT, RESP} state_t;

  state_t r_state;
  logic   r_gnt;
  logic   r_last_grant;
  logic   w_sel;

  // On contention the port that did not win last time goes next.
  always_comb begin
    w_sel = req1_valid;
    if (req0_valid && req1_valid) begin
      w_sel = ~r_last_grant;
    end
  end

`ifdef MEM_ARB_TIMEOUT_EN
  logic [7:0] r_cnt;
  logic       r_err0;
  logic       r_err1;
  logic       r_timeout;
  logic       w_expired;
  logic       w_abort;

  assign w_expired = (r_cnt == 8'(TIMEOUT - 1));
  // A completion seen in WAIT on the expiry cycle still wins over the abort.
  assign w_abort   = w_expired &&
                     ((r_state == ACK) || ((r_state == WAIT) && !mem_output_available));
  assign resp0_err   = r_err0;
  assign resp1_err   = r_err1;
  assign timeout_err = r_timeout;
`else
  assign resp0_err   = 1'b0;
  assign resp1_err   = 1'b0;
  assign timeout_err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state       <= IDLE;
      r_gnt         <= 1'b0;
      r_last_grant  <= 1'b1;
      req0_ready    <= 1'b0;
      req1_ready    <= 1'b0;
      resp0_valid   <= 1'b0;
      resp1_valid   <= 1'b0;
      resp0_rdata   <= '0;
      resp1_rdata   <= '0;
      mem_available <= 1'b0;
      mem_we        <= 1'b0;
      mem_address   <= '0;
      mem_write     <= '0;
`ifdef MEM_ARB_TIMEOUT_EN
      r_cnt         <= '0;
      r_err0        <= 1'b0;
      r_err1        <= 1'b0;
      r_timeout     <= 1'b0;
`endif
    end else begin
      req0_ready    <= 1'b0;
      req1_ready    <= 1'b0;
      resp0_valid   <= 1'b0;
      resp1_valid   <= 1'b0;
      mem_available <= 1'b0;
`ifdef MEM_ARB_TIMEOUT_EN
      r_err0        <= 1'b0;
      r_err1        <= 1'b0;
`endif
      case (r_state)
        IDLE: begin
          if (req0_valid || req1_valid) begin
            r_gnt         <= w_sel;
            r_last_grant  <= w_sel;
            mem_we        <= w_sel ? req1_we    : req0_we;
            mem_address   <= w_sel ? req1_addr  : req0_addr;
            mem_write     <= w_sel ? req1_wdata : req0_wdata;
            mem_available <= 1'b1;
            req0_ready    <= ~w_sel;
            req1_ready    <= w_sel;
            r_state       <= ISSUE;
          end
        end
        ISSUE: begin
          r_state <= ACK;
`ifdef MEM_ARB_TIMEOUT_EN
          r_cnt   <= '0;
`endif
        end
        ACK: begin
          if (!mem_output_available) begin
            r_state <= WAIT;
          end
`ifdef MEM_ARB_TIMEOUT_EN
          r_cnt <= r_cnt + 8'd1;
`endif
        end
        WAIT: begin
          if (mem_output_available) begin
            if (!mem_we) begin
              if (r_gnt) begin
                resp1_rdata <= mem_read;
              end else begin
                resp0_rdata <= mem_read;
              end
            end
            resp0_valid <= ~r_gnt;
            resp1_valid <= r_gnt;
            r_state     <= RESP;
          end
`ifdef MEM_ARB_TIMEOUT_EN
          r_cnt <= r_cnt + 8'd1;
`endif
        end
        RESP: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
`ifdef MEM_ARB_TIMEOUT_EN
      if (w_abort) begin
        r_state     <= RESP;
        resp0_valid <= ~r_gnt;
        resp1_valid <= r_gnt;
        r_err0      <= ~r_gnt;
        r_err1      <= r_gnt;
        r_timeout   <= 1'b1;
        if (r_gnt) begin
          resp1_rdata <= '0;
        end else begin
          resp0_rdata <= '0;
        end
      end
`endif
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a behavioural BSRAM model (fixed turnaround, optional stall).
// Adapts its watchdog expectations to whether MEM_ARB_TIMEOUT_EN is defined.
module tb_mem_arbiter;
  localparam int AW  = 14;
  localparam int DW  = 32;
  localparam int LAT = 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          req0_valid, req0_we, req0_ready;
  logic [AW-1:0] req0_addr;
  logic [DW-1:0] req0_wdata;
  logic          req1_valid, req1_we, req1_ready;
  logic [AW-1:0] req1_addr;
  logic [DW-1:0] req1_wdata;
  logic          resp0_valid, resp0_err, resp1_valid, resp1_err;
  logic [DW-1:0] resp0_rdata, resp1_rdata;
  logic          mem_available, mem_we, mem_output_available, timeout_err;
  logic [AW-1:0] mem_address;
  logic [DW-1:0] mem_write, mem_read;

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_we(req0_we), .req0_addr(req0_addr),
    .req0_wdata(req0_wdata), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_we(req1_we), .req1_addr(req1_addr),
    .req1_wdata(req1_wdata), .req1_ready(req1_ready),
    .resp0_valid(resp0_valid), .resp0_rdata(resp0_rdata), .resp0_err(resp0_err),
    .resp1_valid(resp1_valid), .resp1_rdata(resp1_rdata), .resp1_err(resp1_err),
    .mem_available(mem_available), .mem_we(mem_we), .mem_address(mem_address),
    .mem_write(mem_write), .mem_read(mem_read),
    .mem_output_available(mem_output_available), .timeout_err(timeout_err)
  );

  // RAM model: accepts on mem_available, drops output_available, completes LAT edges later.
  logic [DW-1:0] mem [0:(1<<AW)-1];
  logic          m_busy, m_we, m_stall;
  int            m_cnt;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata;

  always @(posedge clk) begin
    if (!rst_n) begin
      m_busy               <= 1'b0;
      mem_output_available <= 1'b1;
      mem_read             <= '0;
      mem[14'h010]         <= 32'hDEADBEEF;
    end else if (mem_available) begin
      m_busy               <= 1'b1;
      mem_output_available <= 1'b0;
      m_cnt                <= LAT;
      m_addr               <= mem_address;
      m_we                 <= mem_we;
      m_wdata              <= mem_write;
    end else if (m_busy && !m_stall) begin
      if (m_cnt == 0) begin
        m_busy               <= 1'b0;
        mem_output_available <= 1'b1;
        if (m_we) mem[m_addr] <= m_wdata;
        else      mem_read    <= mem[m_addr];
      end else begin
        m_cnt <= m_cnt - 1;
      end
    end
  end

  int            total = 0;
  int            bad   = 0;
  logic [DW-1:0] last_rd [2];

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic chk_all_zero(input string nm);
    chk({nm, " flags"}, {23'd0, req0_ready, req1_ready, resp0_valid, resp1_valid,
        resp0_err, resp1_err, mem_available, mem_we, timeout_err}, '0);
    chk({nm, " addr"}, {18'd0, mem_address}, '0);
    chk({nm, " wdata"}, mem_write, '0);
    chk({nm, " rdata0"}, resp0_rdata, '0);
    chk({nm, " rdata1"}, resp1_rdata, '0);
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    last_rd[0] = '0;
    last_rd[1] = '0;
  endtask

  task automatic drive(input bit p, input bit v, input bit we, input logic [AW-1:0] a,
                       input logic [DW-1:0] wd);
    if (p) begin
      req1_valid = v; req1_we = we; req1_addr = a; req1_wdata = wd;
    end else begin
      req0_valid = v; req0_we = we; req0_addr = a; req0_wdata = wd;
    end
  endtask

  // Drive one request from the IDLE cycle and wait for ready; n returns cycles waited.
  task automatic issue(input string nm, input bit p, input bit we, input logic [AW-1:0] a,
                       input logic [DW-1:0] wd, output bit got, output int n);
    drive(p, 1'b1, we, a, wd);
    got = 1'b0;
    n   = 0;
    while (!got && n < 20) begin
      @(negedge clk);
      n++;
      if ((p ? req1_ready : req0_ready) === 1'b1) got = 1'b1;
    end
    chk({nm, " ready seen"}, {31'd0, got}, 32'd1);
    drive(p, 1'b0, 1'b0, '0, '0);
  endtask

  task automatic do_txn(input string nm, input bit p, input bit we, input logic [AW-1:0] a,
                        input logic [DW-1:0] wd, input logic [DW-1:0] exp_rd);
    bit got, unstable, other;
    int n, avail;
    issue(nm, p, we, a, wd, got, n);
    if (!got) return;
    chk({nm, " ready latency"}, n, 32'd1);
    chk({nm, " issue strobe"}, {30'd0, mem_available, mem_we}, {30'd0, 1'b1, we});
    chk({nm, " issue addr"}, {18'd0, mem_address}, {18'd0, a});
    if (we) chk({nm, " issue wdata"}, mem_write, wd);
    got = 1'b0; unstable = 1'b0; other = 1'b0; n = 0; avail = 1;
    while (!got && n < 60) begin
      @(negedge clk);
      n++;
      if (mem_available) avail++;
      if (mem_address !== a) unstable = 1'b1;
      if ((p ? (req0_ready | resp0_valid) : (req1_ready | resp1_valid)) !== 1'b0) other = 1'b1;
      if ((p ? resp1_valid : resp0_valid) === 1'b1) got = 1'b1;
    end
    chk({nm, " resp seen"}, {31'd0, got}, 32'd1);
    chk({nm, " resp latency"}, n, 32'(3 + LAT));
    chk({nm, " available pulses"}, avail, 32'd1);
    chk({nm, " addr stable"}, {31'd0, unstable}, '0);
    chk({nm, " other port quiet"}, {31'd0, other}, '0);
    chk({nm, " resp err"}, {31'd0, p ? resp1_err : resp0_err}, '0);
    if (!we) last_rd[p] = exp_rd;
    chk({nm, " rdata"}, p ? resp1_rdata : resp0_rdata, last_rd[p]);
    @(negedge clk);
    chk({nm, " resp one cycle"}, {31'd0, p ? resp1_valid : resp0_valid}, '0);
  endtask

  typedef struct {
    bit            p;
    bit            we;
    logic [AW-1:0] a;
    logic [DW-1:0] wd;
    logic [DW-1:0] exp;
  } vec_t;

  vec_t tbl [9];

  initial begin
    bit   got, dual, gap_bad;
    int   n, g, cyc, last_resp, ngap;
    logic [5:0] order;

    tbl[0] = '{1'b0, 1'b0, 14'h0010, 32'h0,        32'hDEADBEEF};
    tbl[1] = '{1'b1, 1'b1, 14'h3FFF, 32'h12345678, 32'h0};
    tbl[2] = '{1'b1, 1'b0, 14'h3FFF, 32'h0,        32'h12345678};
    tbl[3] = '{1'b0, 1'b1, 14'h0000, 32'hA5A55A5A, 32'h0};
    tbl[4] = '{1'b1, 1'b0, 14'h0000, 32'h0,        32'hA5A55A5A};
    tbl[5] = '{1'b0, 1'b0, 14'h3FFF, 32'h0,        32'h12345678};
    tbl[6] = '{1'b0, 1'b1, 14'h2AAA, 32'hFFFFFFFF, 32'h0};
    tbl[7] = '{1'b1, 1'b0, 14'h2AAA, 32'h0,        32'hFFFFFFFF};
    tbl[8] = '{1'b1, 1'b0, 14'h0010, 32'h0,        32'hDEADBEEF};

    m_stall = 1'b0;
    drive(1'b0, 1'b0, 1'b0, '0, '0);
    drive(1'b1, 1'b0, 1'b0, '0, '0);
    apply_reset();
    chk_all_zero("reset");

    for (int i = 0; i < 9; i++) begin
      do_txn($sformatf("vec%0d", i), tbl[i].p, tbl[i].we, tbl[i].a, tbl[i].wd, tbl[i].exp);
    end

    // Contention: both ports held valid from reset; grants must alternate starting at port 0.
    apply_reset();
    drive(1'b0, 1'b1, 1'b0, 14'h0010, '0);
    drive(1'b1, 1'b1, 1'b0, 14'h3FFF, '0);
    g = 0; cyc = 0; last_resp = -1; ngap = 0; dual = 1'b0; gap_bad = 1'b0; order = '0;
    while (g < 6 && cyc < 300) begin
      @(negedge clk);
      cyc++;
      if (req0_ready && req1_ready) dual = 1'b1;
      if (req0_ready || req1_ready) begin
        order[g] = req1_ready;
        g++;
      end
      if (mem_available && last_resp >= 0) begin
        ngap++;
        if (cyc - last_resp != 2) gap_bad = 1'b1;
      end
      if (resp0_valid || resp1_valid) last_resp = cyc;
    end
    drive(1'b0, 1'b0, 1'b0, '0, '0);
    drive(1'b1, 1'b0, 1'b0, '0, '0);
    chk("contention grants", g, 32'd6);
    chk("contention order", {26'd0, order}, {26'd0, 6'b101010});
    chk("contention dual ready", {31'd0, dual}, '0);
    chk("contention gap count", ngap, 32'd5);
    chk("contention gap length", {31'd0, gap_bad}, '0);
    n = 0;
    while (!resp1_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("contention last resp", {31'd0, resp1_valid}, 32'd1);
    @(negedge clk);

    // Reset while the ram is stalled in WAIT.
    m_stall = 1'b1;
    issue("midrst", 1'b0, 1'b0, 14'h0010, '0, got, n);
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk_all_zero("midrst");
    m_stall = 1'b0;
    rst_n   = 1'b1;
    last_rd[0] = '0;
    last_rd[1] = '0;
    n = 0;
    got = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (resp0_valid || resp1_valid) got = 1'b1;
    end
    chk("midrst no resp", {31'd0, got}, '0);
    do_txn("after rst", 1'b0, 1'b0, 14'h0010, '0, 32'hDEADBEEF);

    // Watchdog: ram never completes.
    m_stall = 1'b1;
    issue("wdog", 1'b0, 1'b0, 14'h0020, '0, got, n);
`ifdef MEM_ARB_TIMEOUT_EN
    n = 0;
    got = 1'b0;
    while (!got && n < 40) begin
      @(negedge clk);
      n++;
      if (resp0_valid) got = 1'b1;
    end
    chk("wdog resp seen", {31'd0, got}, 32'd1);
    chk("wdog latency", n, 32'd9);
    chk("wdog err", {31'd0, resp0_err}, 32'd1);
    chk("wdog rdata", resp0_rdata, '0);
    chk("wdog flag", {31'd0, timeout_err}, 32'd1);
    repeat (5) @(negedge clk);
    chk("wdog flag sticky", {31'd0, timeout_err}, 32'd1);
`else
    got = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (resp0_valid || resp1_valid || timeout_err) got = 1'b1;
    end
    chk("wdog off quiet", {31'd0, got}, '0);
    chk("wdog off addr held", {18'd0, mem_address}, {18'd0, 14'h0020});
`endif
    m_stall = 1'b0;
    apply_reset();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global timeout: simulation did not complete");
    $fatal(1, "global timeout");
  end
endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port round-robin arbiter that shares the single-port BSRAM `ram` block between two requesters, typically port 0 for instruction fetch and port 1 for load/store. It grants one request at a time and drives the ram's `available`/`we`/`address`/`write` strobes. It tracks the ram's `output_available` completion flag and returns read data and a completion pulse to the granted port. It sits between the core's fetch and LSU stages and the `ram` instance.

## Interface
- `ADDR_W`, 14: word address width; matches ram `address`.
- `DATA_W`, 32: data width.
- `TIMEOUT`, 64: watchdog limit in cycles, used only when `MEM_ARB_TIMEOUT_EN` is defined; legal range 4..255.
- `clk` in 1: single clock, rising-edge.
- `rst_n` in 1: reset, synchronous, active-low.
- `req0_valid`, `req1_valid` in 1 each: request pending; held until the matching `reqN_ready`.
- `req0_we`, `req1_we` in 1 each: 1 = write, 0 = read.
- `req0_addr`, `req1_addr` in ADDR_W each: word address.
- `req0_wdata`, `req1_wdata` in DATA_W each: write data.
- `req0_ready`, `req1_ready` out 1 each: one-cycle pulse; request latched.
- `resp0_valid`, `resp1_valid` out 1 each: one-cycle completion pulse.
- `resp0_rdata`, `resp1_rdata` out DATA_W each: read data; valid when `respN_valid`=1 and the request was a read.
- `resp0_err`, `resp1_err` out 1 each: qualifies `respN_valid`; 1 = aborted by the watchdog.
- `mem_available` out 1: one-cycle request strobe to ram `available`.
- `mem_we` out 1: to ram `we`.
- `mem_address` out ADDR_W: to ram `address`.
- `mem_write` out DATA_W: to ram `write`.
- `mem_read` in DATA_W: from ram `read`.
- `mem_output_available` in 1: from ram `output_available`.
- `timeout_err` out 1: sticky watchdog flag.

## Operation
- States: IDLE, ISSUE, ACK, WAIT, RESP.
- **IDLE**
  - If either `reqN_valid` is 1, select a port. If both are valid, select the port ≠ `last_grant`.
  - Latch the selected port's addr/we/wdata into `mem_address`/`mem_we`/`mem_write`.
  - Set `gnt` = port and `last_grant` = port. Go to ISSUE.
  - If neither is valid, stay in IDLE.
- **ISSUE** (1 cycle)
  - `mem_available`=1 and `req<gnt>_ready`=1, both registered. Go to ACK.
- **ACK**: stay until `mem_output_available`=0, meaning the ram has accepted the request. Then go to WAIT.
- **WAIT**
  - Stay until `mem_output_available`=1.
  - On that cycle, capture `mem_read` into `resp<gnt>_rdata` and go to RESP.
- **RESP** (1 cycle)
  - `resp<gnt>_valid`=1. Go to IDLE.
  - For writes, `rdata` is don't-care; `valid` still pulses.
- `mem_address`/`mem_we`/`mem_write` stay stable from ISSUE through RESP. They change only on an IDLE grant.
- `respN_rdata` holds its value until the next read completion on that port.
- The non-granted port is never pulsed. Its request waits in IDLE-arbitration order.
- `last_grant` resets to 1, so port 0 wins the first contention.

## Timing
- Reset (`rst_n`=0 at a rising edge):
  - State goes to IDLE.
  - All outputs go to 0: `reqN_ready`, `respN_valid`, `respN_rdata`, `respN_err`, `mem_available`, `mem_we`, `mem_address`, `mem_write`, `timeout_err`.
  - `last_grant`=1.
  - Reset mid-transaction drops the in-flight request with no response. The requester must reissue.
- Request sampled valid in IDLE at edge T: ISSUE during T+1. With ram turnaround of k cycles after ACK, `respN_valid` is asserted at T+3+k at the earliest. Minimum request-to-response is 5 cycles.
- Requesters must deassert or change `reqN_valid` in the cycle after `reqN_ready`. The arbiter does not re-sample until it returns to IDLE.
- Back-to-back traffic: RESP→IDLE→ISSUE, so there is one idle cycle between transactions. With both ports valid continuously, grants strictly alternate 0,1,0,1.
- `mem_available` is never asserted outside ISSUE.

## Configuration
- Macro: `MEM_ARB_TIMEOUT_EN`.
- When defined:
  - An 8-bit counter clears on entry to ACK and increments each cycle in ACK or WAIT.
  - At count = `TIMEOUT`-1 the arbiter goes to RESP with `resp<gnt>_err`=1 and `resp<gnt>_rdata`=0.
  - It sets `timeout_err`=1, which stays set until reset.
- When undefined:
  - No counter is built.
  - `respN_err` and `timeout_err` are tied to 0.
  - ACK and WAIT wait indefinitely.

## Test plan
- **Single read:** reset, ram model preloaded with `mem[0x010]`=0xDEADBEEF; `req0` read addr 0x010 → `req0_ready` pulse 1 cycle after sampling, `mem_available` asserted exactly 1 cycle, `resp0_valid` with `resp0_rdata`=0xDEADBEEF, `resp1_valid` never asserted.
- **Write then read:** `req1` write 0x3FFF←0x12345678, then `req1` read 0x3FFF → second response `rdata`=0x12345678. `mem_address`=0x3FFF is held stable ISSUE..RESP.
- **Contention:** both ports valid continuously for 6 transactions after reset → grant order 0,1,0,1,0,1; exactly one idle cycle between RESP and the next ISSUE.
- **Reset mid-op:** assert `rst_n`=0 while in WAIT → next cycle all outputs 0, state IDLE, no `respN_valid`. A new `req0` completes normally.
- **Watchdog (macro defined, TIMEOUT=8):** ram model never raises `output_available` → `resp0_valid` with `resp0_err`=1 and `rdata`=0 after 8 cycles in ACK/WAIT, `timeout_err` stays 1. Same stimulus with the macro undefined → arbiter stays in WAIT and `timeout_err` stays 0.
